// File: rtl/float_to_fixed_seq.sv
// float_to_fixed_seq
//   Converts an IEEE-754 single-precision value into a signed two's-complement
//   fixed-point number with FRAC fraction bits. It uses a handshaked, multi-cycle
//   state machine. The mantissa is shifted one bit per cycle toward its final
//   alignment.
//
// Parameters
//   WIDTH : fixed-point output width (FRAC+2 <= WIDTH <= 64)
//   FRAC  : number of fraction bits (binary point between bit FRAC and FRAC-1)
//
// Optional feature macro
//   F2X_ROUND_NEAREST_EN : when defined, the result is rounded to nearest-even.
//                          Otherwise the magnitude is truncated toward zero.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   IN_VALID   in   FLOAT is valid
//   IN_READY   out  converter can accept (IDLE only, low while in reset)
//   FLOAT      in   IEEE-754 single input
//   OUT_VALID  out  result valid, held until OUT_READY
//   OUT_READY  in   consumer accepts the result
//   FIXED      out  signed fixed-point result
//   OVF        out  result saturated (too large or +/-inf)
//   UNF        out  nonzero input produced a zero result
//   NAN        out  input was NaN
//   BUSY       out  state machine not in IDLE
module float_to_fixed_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 26
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      FLOAT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] FIXED,
  output logic             OVF,
  output logic             UNF,
  output logic             NAN,
  output logic             BUSY
);

  // The shifter must hold the 24-bit significand and any left-shifted result.
  localparam int MW = (WIDTH > 24) ? WIDTH : 24;
  // One extra bit catches the round-up carry.
  localparam int MR = MW + 1;

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASS,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [31:0]      r_float;
  logic [MW-1:0]    r_mant;
  logic             r_guard;
  logic             r_sticky;
  logic             r_left;
  logic [6:0]       r_cnt;
  logic [WIDTH-1:0] r_fixed;
  logic             r_ovf;
  logic             r_unf;
  logic             r_nan;
  logic             r_out_valid;

  // Fields of the captured operand and the derived shift amount.
  logic             w_sign;
  logic [7:0]       w_exp;
  logic [22:0]      w_man;
  int               w_e;
  int               w_k;
  logic [6:0]       w_k_abs;

  assign w_sign  = r_float[31];
  assign w_exp   = r_float[30:23];
  assign w_man   = r_float[22:0];
  assign w_e     = int'({24'd0, w_exp}) - 127;
  // k is the distance from the significand's LSB weight to the output LSB weight.
  assign w_k     = w_e - 23 + FRAC;
  assign w_k_abs = (w_k < 0) ? 7'(-w_k) : 7'(w_k);

  // Rounding of the aligned magnitude.
  logic             w_round_up;
  logic [MR-1:0]    w_mag;
  logic [WIDTH-1:0] w_mag_trunc;
  logic             w_mag_ovf;

`ifdef F2X_ROUND_NEAREST_EN
  // Round half to even: round up above the half point, or exactly at it when the LSB is odd.
  assign w_round_up = r_guard & (r_sticky | r_mant[0]);
`else
  logic w_unused_gs;
  assign w_unused_gs = r_guard ^ r_sticky;
  assign w_round_up  = 1'b0;
`endif

  assign w_mag       = {1'b0, r_mant} + MR'(w_round_up);
  assign w_mag_trunc = w_mag[WIDTH-1:0];
  // Any magnitude bit at or above the sign position cannot be represented.
  assign w_mag_ovf   = |w_mag[MR-1:WIDTH-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_float     <= '0;
      r_mant      <= '0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_left      <= 1'b0;
      r_cnt       <= '0;
      r_fixed     <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_nan       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (IN_VALID) begin
            r_float <= FLOAT;
            r_state <= S_CLASS;
          end
        end

        S_CLASS: begin
          r_mant   <= MW'({1'b1, w_man});
          r_guard  <= 1'b0;
          r_sticky <= 1'b0;
          r_left   <= (w_k > 0);
          r_cnt    <= w_k_abs;
          if (w_exp == 8'hFF && w_man != 23'd0) begin
            r_fixed     <= '0;
            r_nan       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_exp == 8'hFF) begin
            r_fixed     <= w_sign ? SAT_NEG : SAT_POS;
            r_ovf       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_exp == 8'd0) begin
            // Subnormals are flushed to zero.
            r_fixed     <= '0;
            r_unf       <= |w_man;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_e >= WIDTH - 1 - FRAC) begin
            r_fixed     <= w_sign ? SAT_NEG : SAT_POS;
            r_ovf       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_k < -25) begin
            // Below a quarter LSB: nothing survives even with rounding.
            r_fixed     <= '0;
            r_unf       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= (w_k != 0) ? S_SHIFT : S_ROUND;
          end
        end

        S_SHIFT: begin
          if (r_left) begin
            r_mant <= {r_mant[MW-2:0], 1'b0};
          end else begin
            r_mant   <= {1'b0, r_mant[MW-1:1]};
            r_guard  <= r_mant[0];
            // The old guard bit moves past the guard position into sticky.
            r_sticky <= r_sticky | r_guard;
          end
          r_cnt <= r_cnt - 7'd1;
          if (r_cnt == 7'd1) begin
            r_state <= S_ROUND;
          end
        end

        S_ROUND: begin
          if (w_mag_ovf) begin
            r_fixed <= w_sign ? SAT_NEG : SAT_POS;
            r_ovf   <= 1'b1;
            r_unf   <= 1'b0;
          end else begin
            r_fixed <= w_sign ? -w_mag_trunc : w_mag_trunc;
            r_ovf   <= 1'b0;
            r_unf   <= (w_mag_trunc == '0);
          end
          r_nan       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          if (OUT_READY) begin
            r_out_valid <= 1'b0;
            r_fixed     <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_nan       <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ready is gated by the reset input so it stays low for the whole reset pulse.
  assign IN_READY  = (r_state == S_IDLE) & RST;
  assign BUSY      = (r_state != S_IDLE);
  assign OUT_VALID = r_out_valid;
  assign FIXED     = r_fixed;
  assign OVF       = r_ovf;
  assign UNF       = r_unf;
  assign NAN       = r_nan;

endmodule
